// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding and PC constants for the PC sequencer.
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;
endpackage

// File: rtl/pc_adder_mux.sv
// pc_adder_mux: operand select feeding the single shared 32-bit adder.
module pc_adder_mux
  import pc_sequencer_pkg::*;
(
  input  logic        redirect,
  input  logic [31:0] pc,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  output logic [31:0] sum
);
  logic [31:0] a, b;
  always_comb begin
    a   = redirect ? base : pc;
    b   = redirect ? (offset << 2) : PC_INC;
    sum = a + b;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and fetch FSM applying stall, jump and branch redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic [1:0]  state
);
  state_t      st, nx;
  logic [31:0] pc_nx, base_q, off_q, sum;
  logic        latch;
  pc_adder_mux u_adder (
    .redirect (st == REDIRECT),
    .pc       (pc),
    .base     (base_q),
    .offset   (off_q),
    .sum      (sum)
  );
  always_comb begin
    nx    = st;
    pc_nx = pc;
    latch = 1'b0;
    flush = 1'b0;
    unique case (st)
      IDLE: nx = start ? RUN : IDLE;
      RUN: begin
        if (halt) nx = HALT;
        else if (branch_taken) begin
          nx    = REDIRECT;
          flush = 1'b1;
          latch = 1'b1;
        end else if (jump) begin
          flush = 1'b1;
          pc_nx = {sum[31:28], jump_target, 2'b00};
        end else if (!stall) pc_nx = sum;
      end
      REDIRECT: begin
        pc_nx = sum;
        nx    = halt ? HALT : RUN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      pc     <= RESET_PC;
      base_q <= '0;
      off_q  <= '0;
    end else begin
      st <= nx;
      pc <= pc_nx;
      if (latch) begin
        base_q <= branch_base;
        off_q  <= branch_offset;
      end
    end
  end
  assign fetch_valid = (st == RUN);
  assign state       = st;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; each cycle's expected PC/valid/state is queued and compared after the edge.
module tb_pc_sequencer;
  logic        clk = 0, rst = 1, start = 0, stall = 0, halt = 0, branch_taken = 0, jump = 0;
  logic [31:0] branch_base = 0, branch_offset = 0;
  logic [25:0] jump_target = 0;
  logic [31:0] pc;
  logic        fetch_valid, flush;
  logic [1:0]  state;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic [1:0]  st;
  } exp_t;
  exp_t sb[$];
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_REDIR = 2'd2, S_HALT = 2'd3;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_base(branch_base), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 3;
      if (pc !== e.pc) begin
        errors++;
        $display("FAIL pc at %0t: got %h expected %h", $time, pc, e.pc);
      end
      if (fetch_valid !== e.fv) begin
        errors++;
        $display("FAIL fetch_valid at %0t: got %b expected %b", $time, fetch_valid, e.fv);
      end
      if (state !== e.st) begin
        errors++;
        $display("FAIL state at %0t: got %0d expected %0d", $time, state, e.st);
      end
    end
  end

  task automatic tick(input logic [31:0] p, input logic v, input logic [1:0] s);
    sb.push_back('{pc: p, fv: v, st: s});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; branch_taken = 0; jump = 0; rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    tick(32'h0, 0, S_IDLE);
    rst = 0;
    stall = 1; branch_taken = 1; jump = 1;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush: got %b expected 0", flush);
    end
    tick(32'h0, 0, S_IDLE);
    clear_inputs();
    tick(32'h0, 0, S_IDLE);
  endtask

  task automatic test_sequential();
    start = 1;
    tick(32'h0, 1, S_RUN);
    start = 0;
    tick(32'h4, 1, S_RUN);
    tick(32'h8, 1, S_RUN);
  endtask

  task automatic test_stall();
    stall = 1;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: got %b expected 0", flush);
    end
    tick(32'h8, 1, S_RUN);
    tick(32'h8, 1, S_RUN);
    stall = 0;
    tick(32'hC, 1, S_RUN);
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_base = 32'h10; branch_offset = 32'hFFFF_FFFE;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL branch_flush: got %b expected 1", flush);
    end
    tick(32'hC, 0, S_REDIR);
    branch_taken = 0;
    tick(32'h8, 1, S_RUN);
    tick(32'hC, 1, S_RUN);
  endtask

  task automatic test_branch_jump();
    branch_taken = 1; jump = 1; jump_target = 26'h40;
    branch_base = 32'h1000_0000; branch_offset = 32'h0;
    tick(32'hC, 0, S_REDIR);
    clear_inputs();
    tick(32'h1000_0000, 1, S_RUN);
    jump = 1; jump_target = 26'h40;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL jump_flush: got %b expected 1", flush);
    end
    tick(32'h1000_0100, 1, S_RUN);
    jump = 0;
    tick(32'h1000_0104, 1, S_RUN);
  endtask

  task automatic test_wrap();
    branch_taken = 1; branch_base = 32'hFFFF_FFFC; branch_offset = 32'h0;
    tick(32'h1000_0104, 0, S_REDIR);
    branch_taken = 1; stall = 1; jump = 1; branch_base = 32'h0; branch_offset = 32'h5;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL redirect_flush: got %b expected 0", flush);
    end
    tick(32'hFFFF_FFFC, 1, S_RUN);
    clear_inputs();
    tick(32'h0, 1, S_RUN);
    tick(32'h4, 1, S_RUN);
  endtask

  task automatic test_reset_redirect();
    branch_taken = 1; branch_base = 32'h100; branch_offset = 32'h1;
    tick(32'h4, 0, S_REDIR);
    branch_taken = 0; rst = 1;
    tick(32'h0, 0, S_IDLE);
    rst = 0;
    tick(32'h0, 0, S_IDLE);
  endtask

  task automatic test_halt();
    start = 1;
    tick(32'h0, 1, S_RUN);
    start = 0;
    tick(32'h4, 1, S_RUN);
    halt = 1; branch_taken = 1; jump = 1;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL halt_flush: got %b expected 0", flush);
    end
    tick(32'h4, 0, S_HALT);
    clear_inputs();
    start = 1; jump = 1;
    tick(32'h4, 0, S_HALT);
    tick(32'h4, 0, S_HALT);
    clear_inputs();
    rst = 1;
    tick(32'h0, 0, S_IDLE);
    rst = 0;
  endtask

  task automatic test_halt_in_redirect();
    start = 1;
    tick(32'h0, 1, S_RUN);
    start = 0;
    branch_taken = 1; branch_base = 32'h20; branch_offset = 32'h1;
    tick(32'h0, 0, S_REDIR);
    branch_taken = 0; halt = 1;
    tick(32'h24, 0, S_HALT);
    halt = 0;
    tick(32'h24, 0, S_HALT);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_jump();
    test_wrap();
    test_reset_redirect();
    test_halt();
    test_halt_in_redirect();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
